// File: rtl/sr_drive_pkg.sv
// sr_drive_pkg: shared FSM state type and default timing constants for sr_drive_ctrl
package sr_drive_pkg;
  typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, GAP} state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES = 2;
endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: 2-flop synchronizer, stability debouncer and registered one-cycle rising-edge event
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, db_q, db_d, prev_q, rise_q, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (s2_q != db_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d = (s2_q == db_q || flip) ? '0 : cnt_q + 1'b1;
    db_d = flip ? s2_q : db_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      cnt_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      prev_q <= db_q;
      rise_q <= db_q & ~prev_q;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns bouncing set/reset buttons into non-overlapping active-low pulses for a NAND SR latch
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic reset_btn,
  output logic sbar,
  output logic rbar,
  output logic busy,
  output logic conflict
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  logic set_ev, rst_ev, ev, ev_dir, store, last;
  state_e state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic dir_q, dir_d, pend_q, pend_d, pdir_q, pdir_d;
  logic sbar_q, rbar_q, busy_q, conflict_q;
  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk(clk),
    .rst(rst),
    .btn(set_btn),
    .rise(set_ev)
  );
  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
    .clk(clk),
    .rst(rst),
    .btn(reset_btn),
    .rise(rst_ev)
  );
  always_comb begin
    ev = set_ev ^ rst_ev;
    ev_dir = set_ev;
    last = pcnt_q == PW'(PULSE_CYCLES - 1);
    store = ev && state_q != IDLE && ev_dir != dir_q && !(pend_q && pdir_q == ev_dir);
    pend_d = pend_q || store;
    pdir_d = store ? ev_dir : pdir_q;
    state_d = state_q;
    pcnt_d = '0;
    dir_d = dir_q;
    if (state_q == IDLE) begin
      state_d = ev ? (ev_dir ? SET_PULSE : RST_PULSE) : IDLE;
      dir_d = ev ? ev_dir : dir_q;
    end else if (state_q == GAP) begin
      state_d = pend_d ? (pdir_d ? SET_PULSE : RST_PULSE) : IDLE;
      dir_d = pend_d ? pdir_d : dir_q;
      pend_d = 1'b0;
    end else begin
      state_d = last ? GAP : state_q;
      pcnt_d = last ? '0 : pcnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pcnt_q <= '0;
      dir_q <= 1'b0;
      pend_q <= 1'b0;
      pdir_q <= 1'b0;
      sbar_q <= 1'b1;
      rbar_q <= 1'b1;
      busy_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q <= pcnt_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      pdir_q <= pdir_d;
      sbar_q <= state_d != SET_PULSE;
      rbar_q <= state_d != RST_PULSE;
      busy_q <= state_d != IDLE || pend_d;
      conflict_q <= set_ev & rst_ev;
    end
  end
  assign sbar = sbar_q;
  assign rbar = rbar_q;
  assign busy = busy_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed and randomized checks of sr_drive_ctrl against a time-schedule reference model
module tb_sr_drive_ctrl;
  localparam int D = 4;
  localparam int P = 2;
  localparam int HMAX = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic sbar, rbar, busy, conflict;
  logic sbar_1, rbar_1, busy_1, conflict_1;
  logic sbar_3, rbar_3, busy_3, conflict_3;
  int compared = 0;
  int mismatched = 0;
  int widths_seen = 0;
  int n;
  bit raw_s [HMAX];
  bit raw_r [HMAX];
  bit rise_s [HMAX];
  bit rise_r [HMAX];
  bit db_s, db_r, job_active, job_dir, pend_v, pend_dir;
  int job_start;
  bit exp_sbar, exp_rbar, exp_busy, exp_conflict;
  int run [4];
  logic [3:0] lows;

  always #5 clk = ~clk;

  sr_drive_ctrl dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .sbar(sbar), .rbar(rbar), .busy(busy), .conflict(conflict)
  );
  sr_drive_ctrl #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(1)) u_p1 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .sbar(sbar_1), .rbar(rbar_1), .busy(busy_1), .conflict(conflict_1)
  );
  sr_drive_ctrl #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(3)) u_p3 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .sbar(sbar_3), .rbar(rbar_3), .busy(busy_3), .conflict(conflict_3)
  );

  assign lows = {sbar_1, rbar_1, sbar_3, rbar_3};

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      compared++;
      if (!(sbar | rbar) || !(sbar_1 | rbar_1) || !(sbar_3 | rbar_3)) begin
        mismatched++;
        $display("FAIL never_both t=%0t got sbar/rbar p2=%b%b p1=%b%b p3=%b%b required never 00", $time, sbar, rbar, sbar_1, rbar_1, sbar_3, rbar_3);
      end
      for (int i = 0; i < 4; i++) begin
        if (!lows[i]) run[i] = run[i] + 1;
        else if (run[i] > 0) begin
          compared++;
          widths_seen++;
          if (run[i] != ((i >= 2) ? 1 : 3)) begin
            mismatched++;
            $display("FAIL pulse_width ch=%0d got %0d required %0d", i, run[i], (i >= 2) ? 1 : 3);
          end
          run[i] = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit sync_val(bit which, int k);
    if (k < 2) return 1'b0;
    return which ? raw_s[k-2] : raw_r[k-2];
  endfunction

  function automatic bit settled_away(bit which, int k, bit db);
    for (int i = 0; i < D; i++) if (sync_val(which, k - i) == db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    n = 0;
    db_s = 0;
    db_r = 0;
    job_active = 0;
    job_dir = 0;
    job_start = 0;
    pend_v = 0;
    pend_dir = 0;
    exp_sbar = 1;
    exp_rbar = 1;
    exp_busy = 0;
    exp_conflict = 0;
  endtask

  task automatic tick(input bit s, input bit r);
    bit fs, fr, se, re, ev, dir;
    set_btn = s;
    reset_btn = r;
    @(posedge clk);
    raw_s[n] = s;
    raw_r[n] = r;
    fs = settled_away(1'b1, n, db_s);
    fr = settled_away(1'b0, n, db_r);
    db_s = db_s ^ fs;
    db_r = db_r ^ fr;
    rise_s[n] = fs && db_s;
    rise_r[n] = fr && db_r;
    se = (n >= 2) ? rise_s[n-2] : 1'b0;
    re = (n >= 2) ? rise_r[n-2] : 1'b0;
    exp_conflict = se && re;
    ev = se ^ re;
    dir = se;
    if (job_active) begin
      if (ev && dir != job_dir && !(pend_v && pend_dir == dir)) begin
        pend_v = 1;
        pend_dir = dir;
      end
      if (n == job_start + P + 1) begin
        if (pend_v) begin
          job_start = n;
          job_dir = pend_dir;
          pend_v = 0;
        end else job_active = 0;
      end
    end else if (ev) begin
      job_active = 1;
      job_dir = dir;
      job_start = n;
    end
    exp_sbar = !(job_active && job_dir && n <= job_start + P - 1);
    exp_rbar = !(job_active && !job_dir && n <= job_start + P - 1);
    exp_busy = job_active || pend_v;
    n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    set_btn = 0;
    reset_btn = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1;
    set_btn = 1;
    reset_btn = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if ({sbar, rbar, busy, conflict} !== 4'b1100) begin
        mismatched++;
        $display("FAIL reset_state got %b%b%b%b required 1100", sbar, rbar, busy, conflict);
      end
    end
  endtask

  task automatic test_clean_set();
    int fall = -1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(1, 0);
      if (!sbar && fall < 0) fall = i;
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL clean_set edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
      compared++;
      if (busy !== (i >= 7 && i <= 9)) begin
        mismatched++;
        $display("FAIL clean_set_busy edge=%0d got %b required %b", i, busy, i >= 7 && i <= 9);
      end
    end
    compared++;
    if (fall != 7) begin
      mismatched++;
      $display("FAIL clean_set_fall got edge %0d required 7", fall);
    end
  endtask

  task automatic test_bounce();
    int falls = 0;
    bit prev = 1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick((i >= 20) || ((i / 2) % 2 == 0), 0);
      if (prev && !sbar) falls++;
      prev = sbar;
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL bounce edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
      if (i < 20) begin
        compared++;
        if (sbar !== 1'b1) begin
          mismatched++;
          $display("FAIL bounce_quiet edge=%0d got sbar %b required 1", i, sbar);
        end
      end
    end
    compared++;
    if (falls != 1) begin
      mismatched++;
      $display("FAIL bounce_pulses got %0d required 1", falls);
    end
  endtask

  task automatic test_back_to_back();
    int rfall = -1;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      tick(1, i >= 1);
      if (!rbar && rfall < 0) rfall = i;
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL back_to_back edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
      if (i >= 7 && i <= 12) begin
        compared++;
        if (busy !== 1'b1) begin
          mismatched++;
          $display("FAIL back_to_back_busy edge=%0d got %b required 1", i, busy);
        end
      end
    end
    compared++;
    if (rfall != 10) begin
      mismatched++;
      $display("FAIL back_to_back_rfall got edge %0d required 10", rfall);
    end
  endtask

  task automatic test_conflict();
    int confs = 0;
    int lowc = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1, 1);
      confs += conflict;
      lowc += !sbar + !rbar;
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL conflict edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
    end
    compared++;
    if (confs != 1 || lowc != 0) begin
      mismatched++;
      $display("FAIL conflict_summary got strobes=%0d lows=%0d required 1 and 0", confs, lowc);
    end
  endtask

  task automatic test_async_reset();
    int fall = -1;
    int k = 0;
    do_reset();
    while (sbar === 1'b1 && k < 20) begin
      tick(1, 0);
      k++;
    end
    compared++;
    if (sbar !== 1'b0) begin
      mismatched++;
      $display("FAIL async_pre got sbar %b required 0 within 20 cycles", sbar);
    end
    rst = 1;
    #1;
    compared++;
    if ({sbar, rbar, busy} !== 3'b110) begin
      mismatched++;
      $display("FAIL async_reset got %b%b%b required 110 before any edge", sbar, rbar, busy);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1, 0);
      if (!sbar && fall < 0) fall = i;
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL async_after edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
    end
    compared++;
    if (fall != 7) begin
      mismatched++;
      $display("FAIL async_refall got edge %0d required 7", fall);
    end
  endtask

  task automatic test_random();
    int hs = 0;
    int hr = 0;
    bit ls = 0;
    bit lr = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (hs == 0) begin
        ls = $urandom_range(0, 1);
        hs = $urandom_range(1, 12);
      end
      if (hr == 0) begin
        lr = $urandom_range(0, 1);
        hr = $urandom_range(1, 12);
      end
      hs--;
      hr--;
      tick(ls, lr);
      compared++;
      if ({sbar, rbar, busy, conflict} !== {exp_sbar, exp_rbar, exp_busy, exp_conflict}) begin
        mismatched++;
        $display("FAIL random edge=%0d got %b%b%b%b required %b%b%b%b", i, sbar, rbar, busy, conflict, exp_sbar, exp_rbar, exp_busy, exp_conflict);
      end
    end
    compared++;
    if (widths_seen < 4) begin
      mismatched++;
      $display("FAIL pulse_width_coverage got %0d pulses required at least 4", widths_seen);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_set();
    test_bounce();
    test_back_to_back();
    test_conflict();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a debounced input changes; legal range >= 2.
REQ-002 Parameter PULSE_CYCLES, default 2: length in cycles of each active-low drive pulse; legal range >= 1.
REQ-003 Port clk  input  1: single clock, rising-edge active for all state.
REQ-004 Port rst  input  1: asynchronous active-high reset.
REQ-005 Port set_btn  input  1: raw asynchronous set request, active-high, may bounce.
REQ-006 Port reset_btn  input  1: raw asynchronous reset request, active-high, may bounce.
REQ-007 Port sbar  output  1: active-low set drive to the downstream NAND SR latch.
REQ-008 Port rbar  output  1: active-low reset drive to the downstream NAND SR latch.
REQ-009 Port busy  output  1: high whenever the FSM is not IDLE or a request is pending.
REQ-010 Port conflict  output  1: one-cycle strobe, simultaneous set and reset events rejected.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-012 The debouncer SHALL change its output only after the synchronized value differs from it on DEBOUNCE_CYCLES consecutive edges; any matching cycle clears the counter.
REQ-013 A rising edge of a debounced input SHALL produce a one-cycle internal event; falling edges produce no event.
REQ-014 FSM states SHALL be IDLE, SET_PULSE, RST_PULSE, GAP.
REQ-015 IDLE + set event -> SET_PULSE (sbar=0); IDLE + reset event -> RST_PULSE (rbar=0).
REQ-016 SET_PULSE/RST_PULSE SHALL hold for exactly PULSE_CYCLES cycles, then go to GAP for exactly 1 cycle with sbar=rbar=1.
REQ-017 GAP -> SET_PULSE or RST_PULSE if a request is pending, else IDLE.
REQ-018 sbar and rbar SHALL be registered outputs and SHALL never be 0 in the same cycle.
REQ-019 With a clean input, sbar (rbar) SHALL fall on the (3 + DEBOUNCE_CYCLES)th rising edge after the first edge that samples set_btn (reset_btn) high, starting from IDLE.
REQ-020 An opposite-direction event arriving during a pulse or GAP SHALL be stored in a one-deep pending slot and served after GAP.
REQ-021 A same-direction event arriving during its own pulse, or an event matching an already-pending request, SHALL be dropped.
REQ-022 Set and reset events in the same cycle SHALL both be discarded, assert conflict for that one cycle, and leave the FSM state and pending slot unchanged.
REQ-023 Pulse counter width SHALL be clog2(PULSE_CYCLES+1); debounce counter width clog2(DEBOUNCE_CYCLES+1); no wrap-around is permitted.

Reset
REQ-024 While rst=1, sbar=1, rbar=1, busy=0, conflict=0, FSM=IDLE, pending slot empty, all counters 0, synchronizer and debounced values 0.
REQ-025 Reset asserted mid-pulse SHALL return sbar/rbar to 1 immediately (asynchronously), not at the next edge.
REQ-026 After rst deasserts, a button already held high SHALL be treated as a new rising edge and generate an event once debounced.

Structure
REQ-027 Package sr_drive_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES/PULSE_CYCLES constants.
REQ-028 Sub-module sr_debounce (synchronizer + debouncer + rising-edge event) SHALL be instantiated twice, once per input.

Verification
REQ-029 Reset, clean set_btn high from edge 0, defaults -> sbar=0 on edges 7..8, GAP at 9, IDLE at 10, rbar=1 throughout.
REQ-030 set_btn toggling every 2 cycles for 20 cycles, then held high -> no pulse during bouncing; exactly one sbar pulse after the stable period.
REQ-031 reset event during SET_PULSE -> rbar pulse starts on the edge after GAP; no overlap; busy high continuously.
REQ-032 Both buttons rising on the same edge -> conflict=1 for one cycle, no sbar/rbar pulse.
REQ-033 rst asserted while sbar=0 -> sbar=1 with no clock edge; after release with set_btn still high -> a new sbar pulse after the debounce latency.
REQ-034 Checker every cycle -> never sbar=0 and rbar=0 together; each pulse width equals PULSE_CYCLES for PULSE_CYCLES = 1 and 3.
